// File: rtl/wb_rr_arbiter_4.sv
// Four-master Wishbone round-robin arbiter with a single shared slave port.
// A stalled strobe held too long revokes the grant and parks the bus in DRAIN.
module wb_rr_arbiter_4 #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    // master side
    input  logic [3:0]   i_m_we,
    input  logic [3:0]   i_m_stb,
    input  logic [3:0]   i_m_cyc,
    input  logic [15:0]  i_m_sel,
    input  logic [127:0] i_m_dat,
    input  logic [127:0] i_m_adr,
    output logic [31:0]  o_m_dat,
    output logic [3:0]   o_m_ack,
    output logic [3:0]   o_m_int,
    // slave side
    output logic         o_s_we,
    output logic         o_s_stb,
    output logic         o_s_cyc,
    output logic [3:0]   o_s_sel,
    output logic [31:0]  o_s_dat,
    output logic [31:0]  o_s_adr,
    input  logic [31:0]  i_s_dat,
    input  logic         i_s_ack,
    input  logic         i_s_int,
    // status
    output logic [3:0]   o_grant,
    output logic         o_timeout,
    output logic [1:0]   o_timeout_id
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t        r_state, w_next_state;
    logic [1:0]    r_owner, w_next_owner;
    logic [1:0]    r_last_owner, w_next_last;
    logic [CW-1:0] r_cnt, w_next_cnt;
    logic          r_timeout, w_timeout_set;
    logic [1:0]    r_timeout_id;
    logic [1:0]    w_pick;
    logic          w_granted;
    logic          w_stall;

    assign w_granted = (r_state == GRANTED);
    assign w_stall   = w_granted & i_m_stb[r_owner] & ~i_s_ack;

    // Scan from farthest to nearest so the nearest requester after last_owner wins.
    always_comb begin
        w_pick = r_last_owner + 2'd1;
        for (int i = 4; i >= 1; i--) begin
            if (i_m_cyc[r_last_owner + 2'(i)]) begin
                w_pick = r_last_owner + 2'(i);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_owner  = r_owner;
        w_next_last   = r_last_owner;
        w_next_cnt    = '0;
        w_timeout_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_m_cyc) begin
                    w_next_state = GRANTED;
                    w_next_owner = w_pick;
                end
            end
            GRANTED: begin
                if (!i_m_cyc[r_owner]) begin
                    w_next_state = IDLE;
                    w_next_last  = r_owner;
                end else if (TIMEOUT > 0 && w_stall && r_cnt == CW'(TIMEOUT - 1)) begin
                    w_next_state  = DRAIN;
                    w_timeout_set = 1'b1;
                end else if (w_stall) begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (!i_m_cyc[r_owner]) begin
                    w_next_state = IDLE;
                    w_next_last  = r_owner;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 2'd0;
            r_last_owner <= 2'd3;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= 2'd0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_last_owner <= w_next_last;
            r_cnt        <= w_next_cnt;
            r_timeout    <= w_timeout_set;
            if (w_timeout_set) begin
                r_timeout_id <= r_owner;
            end
        end
    end

    // Slave port mirrors the owner only while GRANTED; DRAIN keeps the grant visible but silent.
    always_comb begin
        o_grant = 4'b0000;
        o_m_ack = 4'b0000;
        o_s_we  = 1'b0;
        o_s_stb = 1'b0;
        o_s_cyc = 1'b0;
        o_s_sel = 4'h0;
        o_s_dat = 32'h0;
        o_s_adr = 32'h0;
        if (r_state != IDLE) begin
            o_grant[r_owner] = 1'b1;
        end
        if (w_granted) begin
            o_s_we           = i_m_we[r_owner];
            o_s_stb          = i_m_stb[r_owner];
            o_s_cyc          = i_m_cyc[r_owner];
            o_s_sel          = i_m_sel[{r_owner, 2'b00} +: 4];
            o_s_dat          = i_m_dat[{r_owner, 5'b00000} +: 32];
            o_s_adr          = i_m_adr[{r_owner, 5'b00000} +: 32];
            o_m_ack[r_owner] = i_s_ack;
        end
    end

    assign o_m_dat      = i_s_dat;
    assign o_m_int      = {4{i_s_int}};
    assign o_timeout    = r_timeout;
    assign o_timeout_id = r_timeout_id;

endmodule
